// File: rtl/ping_array_driver.sv
// Round-robin trigger/echo ranging over CHANNELS single-wire ultrasonic sensors.
// Optional PING_ARRAY_AVG_EN: blend each good sample with the previous valid distance.
module ping_array_driver #(
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 4,
    parameter int TRIG_CYCLES  = 5,
    parameter int RISE_TIMEOUT = 1000,
    parameter int ECHO_TIMEOUT = 20000,
    parameter int GAP_CYCLES   = 200
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            enable,
    inout  logic [CHANNELS-1:0]                             sensor,
    output logic [CHANNELS-1:0]                             listening,
    output logic [CHANNELS*WIDTH-1:0]                       distance,
    output logic [CHANNELS-1:0]                             valid,
    output logic                                            update,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] update_ch,
    output logic [2:0]                                      state
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MAXC = max2(max2(TRIG_CYCLES, RISE_TIMEOUT), max2(ECHO_TIMEOUT, GAP_CYCLES));
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = CW + 4;
    localparam int QW   = max2(PW, WIDTH);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        STORE     = 3'd4,
        GAP       = 3'd5
    } state_e;

    state_e                    state_q;
    logic [CHW-1:0]            ch_q;
    logic [CW-1:0]             cnt_q;
    logic                      timeout_q;
    logic [CHANNELS-1:0]       drive_q;
    logic [CHANNELS-1:0]       sync1_q;
    logic [CHANNELS-1:0]       sync2_q;
    logic                      echo_q;
    logic [CHANNELS*WIDTH-1:0] dist_q;
    logic [CHANNELS-1:0]       valid_q;
    logic                      update_q;
    logic [CHW-1:0]            update_ch_q;

    logic [CHW-1:0]   ch_next_d;
    logic             rise_d;
    logic [PW-1:0]    prod_d;
    logic [QW-1:0]    quot_d;
    logic [WIDTH-1:0] conv_d;
    logic [WIDTH-1:0] sample_d;
`ifdef PING_ARRAY_AVG_EN
    logic [WIDTH-1:0] old_d;
    logic [WIDTH:0]   avg_sum_d;
`endif

    // echo_q lags the synchronized pin by one cycle, so MEASURE counts the full high width.
    always_comb begin
        ch_next_d = (ch_q == CHW'(CHANNELS - 1)) ? '0 : ch_q + CHW'(1);
        rise_d    = sync2_q[ch_q] & ~echo_q;
        prod_d    = PW'(cnt_q) * PW'(11);
        quot_d    = QW'(prod_d >> 6);
        conv_d    = (quot_d > QW'({WIDTH{1'b1}})) ? '1 : quot_d[WIDTH-1:0];
`ifdef PING_ARRAY_AVG_EN
        old_d     = dist_q[ch_q*WIDTH +: WIDTH];
        avg_sum_d = {1'b0, old_d} + {1'b0, conv_d} + {{WIDTH{1'b0}}, 1'b1};
        sample_d  = valid_q[ch_q] ? avg_sum_d[WIDTH:1] : conv_d;
`else
        sample_d  = conv_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
            drive_q     <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            echo_q      <= 1'b0;
            dist_q      <= '0;
            valid_q     <= '0;
            update_q    <= 1'b0;
            update_ch_q <= '0;
        end else begin
            sync1_q  <= sensor;
            sync2_q  <= sync1_q;
            echo_q   <= sync2_q[ch_q];
            update_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    drive_q <= '0;
                    if (enable) begin
                        state_q       <= TRIG;
                        cnt_q         <= '0;
                        drive_q[ch_q] <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
                        drive_q   <= '0;
                        cnt_q     <= '0;
                        timeout_q <= 1'b0;
                        state_q   <= WAIT_RISE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_RISE: begin
                    if (rise_d) begin
                        cnt_q   <= '0;
                        state_q <= MEASURE;
                    end else if (cnt_q == CW'(RISE_TIMEOUT - 1)) begin
                        timeout_q <= 1'b1;
                        state_q   <= STORE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                MEASURE: begin
                    if (echo_q) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(ECHO_TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                            state_q   <= STORE;
                        end
                    end else begin
                        state_q <= STORE;
                    end
                end
                STORE: begin
                    if (!timeout_q) begin
                        dist_q[ch_q*WIDTH +: WIDTH] <= sample_d;
                        valid_q[ch_q]               <= 1'b1;
                    end else begin
                        valid_q[ch_q] <= 1'b0;
                    end
                    update_q    <= 1'b1;
                    update_ch_q <= ch_q;
                    cnt_q       <= '0;
                    state_q     <= GAP;
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        ch_q  <= ch_next_d;
                        if (enable) begin
                            state_q            <= TRIG;
                            drive_q            <= '0;
                            drive_q[ch_next_d] <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_pin
        assign sensor[c] = drive_q[c] ? 1'b1 : 1'bz;
    end

    assign listening = ~drive_q;
    assign distance  = dist_q;
    assign valid     = valid_q;
    assign update    = update_q;
    assign update_ch = update_ch_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ping_array_driver.sv
// Directed + randomized slot sequence for ping_array_driver, checked against a slot-level model.
module tb_ping_array_driver;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int TRIG     = 5;
    localparam int RISE_TO  = 20;
    localparam int ECHO_TO  = 1000;
    localparam int GAP      = 10;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    wire  [CHANNELS-1:0]       sensor;
    logic [CHANNELS-1:0]       echo_drv;
    logic [CHANNELS-1:0]       listening;
    logic [CHANNELS*WIDTH-1:0] distance;
    logic [CHANNELS-1:0]       valid;
    logic                      update;
    logic [0:0]                update_ch;
    logic [2:0]                state;

    int errors = 0;
    int checks = 0;

    int               model_ch;
    logic [WIDTH-1:0] model_dist [CHANNELS];
    bit               model_valid[CHANNELS];

    ping_array_driver #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .TRIG_CYCLES(TRIG),
        .RISE_TIMEOUT(RISE_TO),
        .ECHO_TIMEOUT(ECHO_TO),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sensor(sensor),
        .listening(listening),
        .distance(distance),
        .valid(valid),
        .update(update),
        .update_ch(update_ch),
        .state(state)
    );

    // The sensor model drives the line only while the driver has released it.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_sens
        assign sensor[c] = listening[c] ? echo_drv[c] : 1'bz;
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_ch = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            model_dist[i]  = '0;
            model_valid[i] = 1'b0;
        end
    endtask

    task automatic run_slot(input int len, input bit drop_en);
        int c;
        int n;
        int w;
        int r;
        bit got;
        logic [WIDTH-1:0] expd;
        c = model_ch;
        n = 0;
        while (listening[c] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("trig_seen", 32'(n < 100), 1);
        check("trig_pin_high", 32'(sensor[c]), 1);
        check("trig_other_released", 32'(listening[1-c]), 1);
        w = 0;
        while (listening[c] === 1'b0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("trig_width", w, TRIG);
        got = 1'b0;
        n = 0;
        if (len == 0) begin
            while (update !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rise_timeout_latency", n, RISE_TO + 1);
        end else begin
            repeat ($urandom_range(4, 10)) @(negedge clk);
            echo_drv[c] = 1'b1;
            for (int i = 0; i < len && !got; i++) begin
                @(negedge clk);
                if (drop_en && i == len / 2) enable = 1'b0;
                echo_drv[1-c] = 1'($urandom_range(0, 1));
                if (update === 1'b1) got = 1'b1;
            end
            echo_drv = '0;
            while (!got && n < 50) begin
                @(negedge clk);
                n++;
                if (update === 1'b1) got = 1'b1;
            end
        end
        check("update_seen", 32'(update), 1);
        check("update_ch", 32'(update_ch), c);
        if (len != 0 && len < ECHO_TO) begin
            r = (len * 11) / 64;
            if (r > (1 << WIDTH) - 1) r = (1 << WIDTH) - 1;
`ifdef PING_ARRAY_AVG_EN
            if (model_valid[c]) r = (int'(model_dist[c]) + r + 1) / 2;
`endif
            expd = WIDTH'(r);
            model_dist[c]  = expd;
            model_valid[c] = 1'b1;
        end else begin
            model_valid[c] = 1'b0;
        end
        check("valid_sel", 32'(valid[c]), 32'(model_valid[c]));
        check("distance_sel", 32'(distance[c*WIDTH +: WIDTH]), 32'(model_dist[c]));
        check("valid_other", 32'(valid[1-c]), 32'(model_valid[1-c]));
        check("distance_other", 32'(distance[(1-c)*WIDTH +: WIDTH]), 32'(model_dist[1-c]));
        model_ch = (c + 1) % CHANNELS;
        @(negedge clk);
        check("update_one_shot", 32'(update), 0);
    endtask

    initial begin
        int len;
        int n;
        int trig_seen;
        reset    = 1'b1;
        enable   = 1'b0;
        echo_drv = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_listening", 32'(listening), 3);
        check("rst_valid", 32'(valid), 0);
        check("rst_distance", distance, 0);
        check("rst_update", 32'(update), 0);
        reset  = 1'b0;
        enable = 1'b1;

        run_slot(582, 1'b0);
        check("ch0_582_is_100", 32'(distance[15:0]), 100);
        run_slot(0, 1'b0);
        check("ch1_never_rose_invalid", 32'(valid[1]), 0);
        run_slot(1500, 1'b0);
        check("ch0_echo_timeout_invalid", 32'(valid[0]), 0);
        check("ch0_echo_timeout_held", 32'(distance[15:0]), 100);
        run_slot(int'($urandom_range(1, 900)), 1'b0);
        run_slot(582, 1'b0);
        check("ch0_fresh_raw", 32'(distance[15:0]), 100);
        run_slot(int'($urandom_range(1, 900)), 1'b0);
        run_slot(291, 1'b0);
`ifdef PING_ARRAY_AVG_EN
        check("ch0_second_sample", 32'(distance[15:0]), 75);
`else
        check("ch0_second_sample", 32'(distance[15:0]), 50);
`endif
        for (int k = 0; k < 6; k++) begin
            len = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 1200));
            run_slot(len, 1'b0);
        end

        run_slot(400, 1'b1);
        trig_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (listening !== 2'b11) trig_seen++;
        end
        check("no_trig_after_disable", trig_seen, 0);
        check("idle_after_disable", 32'(state), 0);

        enable = 1'b1;
        n = 0;
        while (listening[model_ch] !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("trig_restart", 32'(n < 20), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_trig_released", 32'(listening), 3);
        check("rst_mid_trig_pin", 32'(sensor[model_ch]), 0);
        check("rst_mid_trig_state", 32'(state), 0);
        check("rst_mid_trig_distance", distance, 0);
        check("rst_mid_trig_valid", 32'(valid), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ping_array_driver.md
PING_ARRAY_DRIVER -- requirements
Module: ping_array_driver

Interface
REQ-001 Parameter WIDTH, default 16: distance width in mm.
REQ-002 Parameter CHANNELS, default 4: number of single-wire ultrasonic sensors.
REQ-003 Parameter TRIG_CYCLES, default 5: trigger pulse length in clk cycles.
REQ-004 Parameter RISE_TIMEOUT, default 1000: max cycles from trigger release to echo rise.
REQ-005 Parameter ECHO_TIMEOUT, default 20000: max echo-high cycles.
REQ-006 Parameter GAP_CYCLES, default 200: idle cycles between channel slots.
REQ-007 clk  input  1  1 MHz system clock; one cycle = 1 us.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 enable  input  1  1 = scan channels continuously; 0 = stop after the current slot.
REQ-010 sensor  inout  CHANNELS  per-channel bidirectional sensor pin.
REQ-011 listening  output  CHANNELS  bit c high while sensor[c] is released (high-Z).
REQ-012 distance  output  CHANNELS*WIDTH  packed per-channel distance; channel c at bits [c*WIDTH +: WIDTH].
REQ-013 valid  output  CHANNELS  bit c high when the last slot of channel c produced a good echo.
REQ-014 update  output  1  one-cycle strobe when a channel slot completes.
REQ-015 update_ch  output  clog2(CHANNELS), minimum 1  channel index qualified by update.
REQ-016 state  output  3  current FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, TRIG=1, WAIT_RISE=2, MEASURE=3, STORE=4, GAP=5.
REQ-018 IDLE: all pins released; when enable=1, go to TRIG on the next cycle with the current channel pointer.
REQ-019 TRIG: drive sensor[ch]=1 for exactly TRIG_CYCLES cycles, listening[ch]=0; all other channels released; then WAIT_RISE.
REQ-020 sensor inputs SHALL pass through a 2-flop synchronizer; all echo decisions use the synchronized value.
REQ-021 WAIT_RISE: on synchronized rise go to MEASURE with counter=0; if RISE_TIMEOUT cycles elapse first, flag timeout and go to STORE.
REQ-022 MEASURE: increment counter each cycle while echo high; on fall go to STORE; if counter reaches ECHO_TIMEOUT, flag timeout and go to STORE.
REQ-023 Distance conversion: d = (count*11)>>6, computed at full precision, saturated to 2^WIDTH-1.
REQ-024 STORE, one cycle: with no timeout, load distance[ch] and set valid[ch]=1; on timeout, clear valid[ch] and hold distance[ch]; pulse update=1 with update_ch=ch.
REQ-025 GAP: stay GAP_CYCLES cycles; then advance ch modulo CHANNELS (CHANNELS-1 wraps to 0); go to TRIG if enable=1, else IDLE.
REQ-026 Deasserting enable mid-slot SHALL NOT abort the slot; the slot completes through STORE and GAP.
REQ-027 Glitches on non-selected channels SHALL be ignored.
REQ-028 A rise already present on entry to WAIT_RISE (line high) SHALL NOT count as a rise; only a 0->1 transition counts.

Reset
REQ-029 reset=1 SHALL asynchronously force: state=IDLE, ch=0, all sensor pins high-Z, listening=all ones, distance=0, valid=0, update=0, counters=0.
REQ-030 reset asserted mid-trigger SHALL release the pin immediately, without waiting for a clock edge.

Configuration
REQ-031 With macro PING_ARRAY_AVG_EN defined, a good sample SHALL store (old+new+1)>>1 when valid[ch] was 1, else the raw sample.
REQ-032 Without PING_ARRAY_AVG_EN, a good sample SHALL store the raw converted value; no averaging logic is synthesized.

Verification (CHANNELS=2, TRIG_CYCLES=5, RISE_TIMEOUT=20, ECHO_TIMEOUT=1000, GAP_CYCLES=10)
REQ-033 enable=1, ch0 echo high 582 cycles -> distance[0]=100, valid[0]=1, update with update_ch=0; sensor[0] driven high exactly 5 cycles.
REQ-034 ch1 echo never rises -> valid[1]=0, distance[1] unchanged, update with update_ch=1 after 20 wait cycles; ch pointer wraps to 0.
REQ-035 ch0 echo held high 1500 cycles -> MEASURE exits at count 1000, valid[0]=0.
REQ-036 With PING_ARRAY_AVG_EN: ch0 echoes 582 then 291 cycles -> distance[0]=100, then 75; without the macro -> 100, then 50.
REQ-037 reset pulse during TRIG -> sensor[0] high-Z within the same cycle, state=0, distance=0, valid=0.
REQ-038 enable dropped during MEASURE -> slot completes, update fires, FSM returns to IDLE after GAP with no new trigger.
